// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encodings used by the
// combinational datapath and by anything that drives the opcode port.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_ADD  = 3'b010,
        OP_MUL  = 3'b011,
        OP_SUB  = 3'b100,
        OP_DIV  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } alu_op_e;

    localparam int ALU_OPCODE_W = 3;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Combinational next-value logic for the ALU: result, odd parity over
// arithmetic results, and the invalid-operation flag.
module alu_comb
    import alu_pkg::*;
#(
    parameter int width = 4
) (
    input  logic                    full_adder,
    input  logic [width:0]          A,
    input  logic [width:0]          B,
    input  logic                    Cin,
    input  logic                    red_A,
    input  logic                    red_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic [ALU_OPCODE_W-1:0] opcode,
    output logic [2*width:0]        out_d,
    output logic                    odd_parity_d,
    output logic                    invalid_d
);

    localparam int RW = 2 * width + 1;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] sum_ext;
    logic [RW-1:0] prod_trunc;
    logic [RW-1:0] diff_ext;
    logic [RW-1:0] div_ext;
    logic [width:0] diff;
    logic [width:0] divisor;
    logic [width:0] quot;
    logic           a_zero;
    logic           b_zero;
    logic           red_any;

    // Every arithmetic candidate is computed in parallel; the decode below only selects.
    always_comb begin
        a_ext      = {{width{1'b0}}, A};
        b_ext      = {{width{1'b0}}, B};
        a_zero     = (A == '0);
        b_zero     = (B == '0);
        red_any    = red_A | red_B;
        sum_ext    = a_ext + b_ext + {{(RW-1){1'b0}}, full_adder & Cin};
        prod_trunc = a_ext * b_ext;
        diff       = (A > B) ? (A - B) : (B - A);
        diff_ext   = {{width{1'b0}}, diff};
        // Divisor forced to 1 when B is zero so the divider never sees zero.
        divisor    = b_zero ? {{width{1'b0}}, 1'b1} : B;
        quot       = A / divisor;
        if (a_zero) begin
            div_ext = b_ext;
        end else if (b_zero) begin
            div_ext = a_ext;
        end else begin
            div_ext = {{width{1'b0}}, quot};
        end
    end

    logic [RW-1:0] arith_res;
    logic          is_arith;

    always_comb begin
        out_d        = '0;
        odd_parity_d = 1'b0;
        invalid_d    = 1'b0;
        arith_res    = '0;
        is_arith     = 1'b0;
        if (bypass_A) begin
            out_d = a_ext;
        end else if (bypass_B) begin
            out_d = b_ext;
        end else begin
            case (opcode)
                OP_AND: begin
                    if (red_A)      out_d = {{(RW-1){1'b0}}, &A};
                    else if (red_B) out_d = {{(RW-1){1'b0}}, &B};
                    else            out_d = a_ext & b_ext;
                end
                OP_XOR: begin
                    if (red_A)      out_d = {{(RW-1){1'b0}}, ^A};
                    else if (red_B) out_d = {{(RW-1){1'b0}}, ^B};
                    else            out_d = a_ext ^ b_ext;
                end
                OP_ADD: begin
                    arith_res = sum_ext;
                    is_arith  = 1'b1;
                    invalid_d = red_any;
                end
                OP_MUL: begin
                    arith_res = prod_trunc;
                    is_arith  = 1'b1;
                    invalid_d = red_any;
                end
                OP_SUB: begin
                    arith_res = diff_ext;
                    is_arith  = 1'b1;
                    invalid_d = red_any;
                end
                OP_DIV: begin
                    arith_res = div_ext;
                    is_arith  = 1'b1;
                    invalid_d = red_any | a_zero | b_zero;
                end
                default: begin
                    invalid_d = 1'b1;
                end
            endcase
        end
        if (is_arith) begin
            out_d        = arith_res;
            odd_parity_d = ~^arith_res;
        end
    end

endmodule : alu_comb

// File: rtl/alu_core.sv
// Registered ALU top: all operation logic lives in alu_comb; this level
// holds the single output register stage with asynchronous clear.
module alu_core
    import alu_pkg::*;
#(
    parameter int width = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    full_adder,
    input  logic [width:0]          A,
    input  logic [width:0]          B,
    input  logic                    Cin,
    input  logic                    red_A,
    input  logic                    red_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic [ALU_OPCODE_W-1:0] opcode,
    output logic [2*width:0]        out,
    output logic                    odd_parity,
    output logic                    invalid
);

    logic [2*width:0] out_d;
    logic [2*width:0] out_q;
    logic             odd_parity_d;
    logic             odd_parity_q;
    logic             invalid_d;
    logic             invalid_q;

    alu_comb #(
        .width(width)
    ) u_comb (
        .full_adder   (full_adder),
        .A            (A),
        .B            (B),
        .Cin          (Cin),
        .red_A        (red_A),
        .red_B        (red_B),
        .bypass_A     (bypass_A),
        .bypass_B     (bypass_B),
        .opcode       (opcode),
        .out_d        (out_d),
        .odd_parity_d (odd_parity_d),
        .invalid_d    (invalid_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            odd_parity_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            odd_parity_q <= odd_parity_d;
            invalid_q    <= invalid_d;
        end
    end

    assign out        = out_q;
    assign odd_parity = odd_parity_q;
    assign invalid    = invalid_q;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: each scenario queues expected results as it
// drives stimulus and pops them one cycle later when the registered outputs update.
module tb_alu_core;

    localparam int W  = 4;
    localparam int RW = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          full_adder;
    logic [W:0]    A;
    logic [W:0]    B;
    logic          Cin;
    logic          red_A;
    logic          red_B;
    logic          bypass_A;
    logic          bypass_B;
    logic [2:0]    opcode;
    logic [RW-1:0] out;
    logic          odd_parity;
    logic          invalid;

    typedef struct {
        logic       ba, bb, fa, cin, ra, rb;
        logic [2:0] op;
        logic [W:0] a, b;
    } stim_t;

    typedef struct {
        logic [RW-1:0] out;
        logic          par;
        logic          inv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_core #(.width(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .full_adder (full_adder),
        .A          (A),
        .B          (B),
        .Cin        (Cin),
        .red_A      (red_A),
        .red_B      (red_B),
        .bypass_A   (bypass_A),
        .bypass_B   (bypass_B),
        .opcode     (opcode),
        .out        (out),
        .odd_parity (odd_parity),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(logic ba, logic bb, logic fa, logic cin, logic ra,
                                 logic rb, logic [2:0] op, int a, int b);
        stim_t s;
        s.ba = ba; s.bb = bb; s.fa = fa; s.cin = cin; s.ra = ra; s.rb = rb;
        s.op = op;
        s.a  = a[W:0];
        s.b  = b[W:0];
        return s;
    endfunction

    function automatic exp_t ex(int o, logic p, logic i);
        exp_t e;
        e.out = o[RW-1:0];
        e.par = p;
        e.inv = i;
        return e;
    endfunction

    // Integer reference model used for randomised traffic.
    function automatic exp_t model(stim_t s);
        int   a = int'(s.a);
        int   b = int'(s.b);
        int   r = 0;
        logic arith = 1'b0;
        logic iv = 1'b0;
        exp_t e;
        if (s.ba) r = a;
        else if (s.bb) r = b;
        else begin
            case (s.op)
                3'b000: r = s.ra ? int'(a == 31) : s.rb ? int'(b == 31) : (a & b);
                3'b001: r = s.ra ? ($countones(s.a) % 2) : s.rb ? ($countones(s.b) % 2) : (a ^ b);
                3'b010: begin r = a + b + ((s.fa && s.cin) ? 1 : 0); arith = 1'b1; end
                3'b011: begin r = (a * b) % (1 << RW); arith = 1'b1; end
                3'b100: begin r = (a > b) ? a - b : b - a; arith = 1'b1; end
                3'b101: begin
                    r = (a == 0) ? b : (b == 0) ? a : a / b;
                    arith = 1'b1;
                    iv = (a == 0) || (b == 0);
                end
                default: iv = 1'b1;
            endcase
            if (arith) iv = iv | s.ra | s.rb;
        end
        e.out = r[RW-1:0];
        e.par = arith && ($countones(r) % 2 == 0);
        e.inv = iv;
        return e;
    endfunction

    task automatic drive(stim_t s, exp_t e);
        bypass_A = s.ba; bypass_B = s.bb; full_adder = s.fa; Cin = s.cin;
        red_A = s.ra; red_B = s.rb; opcode = s.op; A = s.a; B = s.b;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 1, 0, 3'b010, 20, 15), ex(35, 0, 1));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, odd_parity, invalid} !== {RW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_hold got out=%0d par=%0b inv=%0b want 0 0 0", out, odd_parity, invalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(string name, stim_t s[], exp_t e[]);
        exp_t x;
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            drive(s[i], e[i]);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            checks++;
            if (out !== x.out) begin
                errors++;
                $display("[TB] FAIL %s[%0d] out got %0d want %0d", name, i, out, x.out);
            end
            checks++;
            if (odd_parity !== x.par) begin
                errors++;
                $display("[TB] FAIL %s[%0d] parity got %0b want %0b", name, i, odd_parity, x.par);
            end
            checks++;
            if (invalid !== x.inv) begin
                errors++;
                $display("[TB] FAIL %s[%0d] invalid got %0b want %0b", name, i, invalid, x.inv);
            end
        end
    endtask

    task automatic test_bypass();
        test_directed("bypass",
            '{mk(1, 1, 0, 0, 1, 1, 3'b110, 13, 7), mk(0, 1, 0, 0, 1, 1, 3'b110, 13, 7)},
            '{ex(13, 0, 0), ex(7, 0, 0)});
    endtask

    task automatic test_reduction();
        test_directed("reduce",
            '{mk(0, 0, 0, 0, 1, 0, 3'b000, 31, 0), mk(0, 0, 0, 0, 0, 0, 3'b000, 21, 15),
              mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 7),  mk(0, 0, 0, 0, 0, 0, 3'b001, 21, 15)},
            '{ex(1, 0, 0), ex(5, 0, 0), ex(1, 0, 0), ex(26, 0, 0)});
    endtask

    task automatic test_arith();
        test_directed("arith",
            '{mk(0, 0, 1, 1, 0, 0, 3'b010, 20, 15), mk(0, 0, 0, 1, 1, 0, 3'b010, 20, 15),
              mk(0, 0, 0, 0, 0, 0, 3'b011, 31, 31), mk(0, 0, 0, 0, 0, 0, 3'b100, 3, 10),
              mk(0, 0, 0, 0, 0, 0, 3'b100, 9, 9),   mk(0, 0, 0, 0, 0, 0, 3'b100, 12, 5)},
            '{ex(36, 1, 0), ex(35, 0, 1), ex(449, 1, 0), ex(7, 0, 0), ex(0, 1, 0), ex(7, 0, 0)});
    endtask

    task automatic test_div();
        test_directed("div",
            '{mk(0, 0, 0, 0, 0, 0, 3'b101, 17, 4), mk(0, 0, 0, 0, 0, 0, 3'b101, 17, 0),
              mk(0, 0, 0, 0, 0, 0, 3'b101, 0, 6),  mk(0, 0, 0, 0, 0, 1, 3'b101, 17, 4)},
            '{ex(4, 0, 0), ex(17, 1, 1), ex(6, 1, 1), ex(4, 0, 1)});
    endtask

    task automatic test_reserved();
        stim_t s[8];
        exp_t  e[8];
        for (int i = 0; i < 8; i++) begin
            s[i] = mk(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      (i % 2 == 0) ? 3'b111 : 3'b110, int'($urandom_range(1, 31)),
                      int'($urandom_range(1, 31)));
            e[i] = ex(0, 0, 1);
        end
        test_directed("reserved", s, e);
    endtask

    task automatic test_back_to_back();
        stim_t s[40];
        exp_t  e[40];
        for (int i = 0; i < 40; i++) begin
            s[i] = mk(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)));
            e[i] = model(s[i]);
        end
        test_directed("b2b", s, e);
    endtask

    task automatic test_reset_mid();
        exp_t x;
        test_directed("pre_reset", '{mk(0, 0, 1, 1, 0, 0, 3'b010, 20, 15)}, '{ex(36, 1, 0)});
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 3'b111, 5, 5), ex(0, 0, 1));
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, odd_parity, invalid} !== {RW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_clear got out=%0d par=%0b inv=%0b want 0 0 0", out, odd_parity, invalid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out, odd_parity, invalid} !== {RW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_held got out=%0d par=%0b inv=%0b want 0 0 0", out, odd_parity, invalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 3'b111, 5, 5), ex(0, 0, 1));
        #1;
        checks++;
        if ({out, odd_parity, invalid} !== {RW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_release got out=%0d par=%0b inv=%0b want 0 0 0", out, odd_parity, invalid);
        end
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        if ({out, odd_parity, invalid} !== {x.out, x.par, x.inv}) begin
            errors++;
            $display("[TB] FAIL first_edge got out=%0d par=%0b inv=%0b want %0d %0b %0b",
                     out, odd_parity, invalid, x.out, x.par, x.inv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_reduction();
        test_arith();
        test_div();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_core

// File: doc/alu_core.md
Name: alu_core

Overview:
- Parameterised, registered ALU.
- Operates on two (width+1)-bit unsigned operands.
- Supports bitwise/reduction AND and XOR, add (optional carry-in), multiply, absolute difference, and divide.
- Produces a (2*width+1)-bit result, an odd-parity bit for arithmetic results, and an invalid-operation flag.
- Sits as a leaf datapath block. One clock, single-cycle registered latency.

Parameters:
- width, 4, operand MSB index; operands are width+1 bits, result is 2*width+1 bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- full_adder  input  1  when 1, ADD includes Cin.
- A  input  width+1  operand A, unsigned.
- B  input  width+1  operand B, unsigned.
- Cin  input  1  carry-in for ADD.
- red_A  input  1  reduction-on-A request.
- red_B  input  1  reduction-on-B request.
- bypass_A  input  1  pass A to out.
- bypass_B  input  1  pass B to out.
- opcode  input  3  operation select.
- out  output  2*width+1  registered result.
- odd_parity  output  1  registered parity bit.
- invalid  output  1  registered invalid-operation flag.

Behaviour:
- Reset: rst_n low asynchronously clears out, odd_parity and invalid to 0. Clearing is immediate, including mid-operation.
- Latency: inputs are sampled on each rising clk edge. Outputs reflect them after that edge (1 cycle). No handshake; a new operation may start every cycle.
- Priority: bypass_A > bypass_B > opcode decode.
  - bypass_A=1: out=zero-extended A, parity=0, invalid=0, regardless of opcode or red flags.
  - bypass_B=1 (bypass_A=0): out=B, parity=0, invalid=0.
- 000 AND: red_A → out=&A (1 bit, zero-extended); else red_B → &B; else A&B. invalid=0, parity=0.
- 001 XOR: same selection using ^A, ^B, A^B. invalid=0, parity=0.
- 010 ADD: out=A+B+Cin if full_adder=1, else A+B (Cin ignored). Result always computed. invalid=red_A|red_B.
- 011 MUL: out=A*B truncated to the low 2*width+1 bits. invalid=red_A|red_B.
- 100 SUB: out=A-B if A>B, else B-A (absolute difference; A==B gives 0). invalid=red_A|red_B.
- 101 DIV:
  - A!=0 and B!=0: out=A/B, truncating integer division.
  - A==0: out=B.
  - Else (B==0): out=A.
  - invalid=red_A|red_B|(A==0)|(B==0). No division by zero is ever evaluated.
- 110, 111: out=0, parity=0, invalid=1. Red flags and Cin are ignored.
- Parity for ADD/MUL/SUB/DIV: odd_parity = ~^out, computed over the full final (truncated) out. It is 1 when out holds an even number of ones. Red flags do not suppress the result or the parity.
- Red flags set with bypass or with AND/XOR do not assert invalid.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND=3'b000, OP_XOR=3'b001, OP_ADD=3'b010, OP_MUL=3'b011, OP_SUB=3'b100, OP_DIV=3'b101.
  - 110/111 are reserved.
  - Optional opcode enum typedef.
- One sub-module alu_comb: purely combinational next-value logic for out, odd_parity and invalid.
- alu_core holds only the output register with async reset.

Test Plan:
- Bypass priority: bypass_A=1, bypass_B=1, A=13, B=7, opcode=3'b110 → next cycle out=13, invalid=0, odd_parity=0. Then bypass_A=0 → out=7.
- Reductions: opcode=000, red_A=1, A=5'h1F → out=1, invalid=0. Then red_A=0, red_B=0, A=5'h15, B=5'h0F → out=5'h05. opcode=001, red_B=1, B=5'b00111 → out=1.
- ADD: full_adder=1, A=20, B=15, Cin=1 → out=36, odd_parity=1, invalid=0. full_adder=0 with red_A=1, same operands → out=35, odd_parity=0, invalid=1.
- MUL and SUB:
  - MUL: A=31, B=31 → out=449 (truncated), odd_parity=1, invalid=0.
  - SUB: A=3, B=10 → out=7, odd_parity=0.
  - SUB: A=B=9 → out=0, odd_parity=1.
- DIV edge cases:
  - A=17, B=4 → out=4, invalid=0, odd_parity=0.
  - A=17, B=0 → out=17, invalid=1, odd_parity=1.
  - A=0, B=6 → out=6, invalid=1.
  - A=17, B=4, red_B=1 → out=4, invalid=1.
- Reserved opcode and reset:
  - opcode=111 with random A/B/Cin → out=0, odd_parity=0, invalid=1.
  - Assert rst_n=0 between clock edges → all outputs 0 immediately, held until the first edge after release.
